nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder.sv | 102 ++++++++++
 tb/tb_nibble_serial_adder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Wide unsigned adder that reuses one 4-bit ripple-carry slice, one nibble per clock, LSB nibble first.
// A registered carry links the passes; sum/cout are held until the consumer takes them.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one nibble pass per clock, idx selects the slice
// DONE  | result presented, out_valid high until out_ready
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;

    logic [IDXW+1:0]   w_base;
    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic [4:0]        w_nib;

    // Bit offset of the current nibble is just idx shifted left by two.
    assign w_base  = {r_idx, 2'b00};
    assign w_a_nib = r_a[w_base +: 4];
    assign w_b_nib = r_b[w_base +: 4];
    assign w_nib   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[w_base +: 4] <= w_nib[3:0];
                    r_carry            <= w_nib[4];
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_nib[4];
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshake outputs depend on state only, never on in_valid/out_ready.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomised and directed bench for nibble_serial_adder (WIDTH=16) against an arithmetic reference model.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain full-width unsigned addition.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mc,
                         output logic [15:0] es, output logic ec);
        logic [16:0] t;
        t  = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
        es = t[15:0];
        ec = t[16];
    endtask

    // Offers one operation, scrambles operands after accept, waits for out_valid (lat=-1 on timeout).
    task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic oc,
                          output logic [15:0] rs, output logic rc, output int lat, output logic rbusy);
        int n;
        a = oa; b = ob; cin = oc; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        lat = -1; rs = '0; rc = 1'b0; rbusy = 1'b0;
        if (in_ready) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            lat = 0;
            while (!out_valid && lat < 20) begin
                @(posedge clk); #1; lat++;
            end
            if (!out_valid) lat = -1;
            rs = sum; rc = cout; rbusy = busy;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({cout, sum} !== 17'd0) begin failures++; $display("FAIL reset_sum got=%b_%h exp=0_0000", cout, sum); end
    endtask

    task automatic test_directed();
        logic [15:0] va [4] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0000};
        logic [15:0] vb [4] = '{16'h4321, 16'h0001, 16'hFFFF, 16'h0000};
        logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] es [4] = '{16'h5555, 16'h0000, 16'hFFFF, 16'h0001};
        logic        ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] rs;
        logic        rc, rb;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], rs, rc, lat, rb);
            checks++; if (lat != 4) begin failures++; $display("FAIL dir_latency[%0d] got=%0d exp=4", i, lat); end
            checks++; if (rs !== es[i]) begin failures++; $display("FAIL dir_sum[%0d] got=%h exp=%h", i, rs, es[i]); end
            checks++; if (rc !== ec[i]) begin failures++; $display("FAIL dir_cout[%0d] got=%b exp=%b", i, rc, ec[i]); end
            checks++; if (rb !== 1'b1) begin failures++; $display("FAIL dir_busy[%0d] got=%b exp=1", i, rb); end
            take_result();
        end
    endtask

    task automatic test_random();
        logic [15:0] ra, rbv, rs, es;
        logic        rcin, rc, ec, bz;
        int          lat;
        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom); rbv = 16'($urandom); rcin = 1'($urandom);
            model(ra, rbv, rcin, es, ec);
            run_op(ra, rbv, rcin, rs, rc, lat, bz);
            checks++; if (lat != 4) begin failures++; $display("FAIL rnd_latency[%0d] got=%0d exp=4", i, lat); end
            checks++; if ({rc, rs} !== {ec, es}) begin
                failures++; $display("FAIL rnd_result[%0d] %h+%h+%b got=%b_%h exp=%b_%h", i, ra, rbv, rcin, rc, rs, ec, es);
            end
            take_result();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] rs;
        logic        rc, bz;
        int          lat;
        run_op(16'h00F0, 16'h0010, 1'b0, rs, rc, lat, bz);
        checks++; if ({rc, rs} !== {1'b0, 16'h0100}) begin failures++; $display("FAIL bp_first got=%b_%h exp=0_0100", rc, rs); end
        out_ready = 1'b0;
        a = 16'hAAAA; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++; if ({out_valid, in_ready, cout, sum} !== {1'b1, 1'b0, 1'b0, 16'h0100}) begin
                failures++; $display("FAIL bp_hold[%0d] got ov=%b ir=%b %b_%h exp ov=1 ir=0 0_0100", i, out_valid, in_ready, cout, sum);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 16'h0100}) begin
            failures++; $display("FAIL bp_release got ov=%b ir=%b sum=%h exp ov=0 ir=1 sum=0100", out_valid, in_ready, sum);
        end
        run_op(16'hAAAA, 16'h1111, 1'b0, rs, rc, lat, bz);
        checks++; if (lat != 4) begin failures++; $display("FAIL bp_queued_latency got=%0d exp=4", lat); end
        checks++; if ({rc, rs} !== {1'b0, 16'hBBBB}) begin failures++; $display("FAIL bp_queued got=%b_%h exp=0_bbbb", rc, rs); end
        take_result();
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] rs;
        logic        rc, bz;
        int          lat;
        a = 16'h8888; b = 16'h8888; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, in_ready, busy, cout, sum} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
            failures++; $display("FAIL midrst got ov=%b ir=%b busy=%b %b_%h exp ov=0 ir=1 busy=0 0_0000", out_valid, in_ready, busy, cout, sum);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_partial got=%b exp=0", out_valid); end
        run_op(16'h0101, 16'h0202, 1'b0, rs, rc, lat, bz);
        checks++; if (lat != 4) begin failures++; $display("FAIL midrst_after_latency got=%0d exp=4", lat); end
        checks++; if ({rc, rs} !== {1'b0, 16'h0303}) begin failures++; $display("FAIL midrst_after got=%b_%h exp=0_0303", rc, rs); end
        take_result();
    endtask

    task automatic test_back_to_back();
        logic [15:0] pa [2], pb [2], es [2], rsum [2];
        logic        pc [2], ec [2], rcout [2];
        int          acc [2], hs [2];
        int          cyc, na, nh;
        logic        do_acc, do_hs;
        for (int i = 0; i < 2; i++) begin
            pa[i] = 16'($urandom); pb[i] = 16'($urandom); pc[i] = 1'($urandom);
            model(pa[i], pb[i], pc[i], es[i], ec[i]);
            acc[i] = 0; hs[i] = 0; rsum[i] = '0; rcout[i] = 1'b0;
        end
        cyc = 0; na = 0; nh = 0;
        out_ready = 1'b1;
        a = pa[0]; b = pb[0]; cin = pc[0]; in_valid = 1'b1;
        while ((na < 2 || nh < 2) && cyc < 60) begin
            do_acc = in_valid && in_ready;
            do_hs  = out_valid && out_ready;
            if (do_hs && nh < 2) begin hs[nh] = cyc; rsum[nh] = sum; rcout[nh] = cout; nh++; end
            if (do_acc && na < 2) begin acc[na] = cyc; na++; end
            @(posedge clk); #1; cyc++;
            if (do_acc) begin
                if (na == 1) begin a = pa[1]; b = pb[1]; cin = pc[1]; end
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (na != 2 || nh != 2) begin failures++; $display("FAIL b2b_complete got acc=%0d hs=%0d exp acc=2 hs=2", na, nh); end
        checks++; if (acc[1] - acc[0] != 6) begin failures++; $display("FAIL b2b_spacing got=%0d exp=6", acc[1] - acc[0]); end
        checks++; if (acc[1] - hs[0] != 1) begin failures++; $display("FAIL b2b_reaccept got=%0d exp=1", acc[1] - hs[0]); end
        for (int i = 0; i < 2; i++) begin
            checks++; if ({rcout[i], rsum[i]} !== {ec[i], es[i]}) begin
                failures++; $display("FAIL b2b_result[%0d] got=%b_%h exp=%b_%h", i, rcout[i], rsum[i], ec[i], es[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
